// File: rtl/alu_cmd_sequencer.sv
// Initiator for the 4-bit ALU: takes commands over valid/ready, drives registered ALU pins,
// captures the ALU outputs one cycle later and queues them in a small response FIFO.
module alu_cmd_sequencer #(
  parameter int WIDTH     = 4,
  parameter int RSP_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic             cmd_acc,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_overflow,
  output logic             rsp_illegal,
  output logic             busy
);

  localparam int PTR_W   = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W   = $clog2(RSP_DEPTH + 1);
  localparam int ENTRY_W = WIDTH + 3;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RSP_DEPTH);

  typedef enum logic {IDLE, EXEC} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   alu_a_q, alu_a_d;
  logic [WIDTH-1:0]   alu_b_q, alu_b_d;
  logic [2:0]         alu_op_q, alu_op_d;
  logic               illegal_q, illegal_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [ENTRY_W-1:0] mem_q [RSP_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic               accept;
  logic               push;
  logic               pop;
  logic               op_legal;
  logic               op_has_ovf;
  logic [ENTRY_W-1:0] push_entry;
  logic [ENTRY_W-1:0] head_entry;

  always_comb begin
    op_legal   = (cmd_op == 3'b000) || (cmd_op == 3'b001) || (cmd_op == 3'b010) ||
                 (cmd_op == 3'b110) || (cmd_op == 3'b111);
    op_has_ovf = (alu_op_q == 3'b010) || (alu_op_q == 3'b110) || (alu_op_q == 3'b111);
  end

  always_comb begin
    state_d   = state_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_op_d  = alu_op_q;
    illegal_d = illegal_q;
    cmd_ready = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    push      = 1'b0;
    case (state_q)
      IDLE: begin
        // Only accept when the response has a guaranteed slot; held low while in reset.
        cmd_ready = !rst && (count_q < DEPTH_C);
        accept    = cmd_valid && cmd_ready;
        if (accept) begin
          alu_a_d   = cmd_acc ? acc_q : cmd_a;
          alu_b_d   = cmd_b;
          alu_op_d  = cmd_op;
          illegal_d = !op_legal;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        busy    = 1'b1;
        push    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    // Illegal opcodes still exercise the ALU pins but return a clean, tagged entry.
    if (illegal_q) begin
      push_entry = {{WIDTH{1'b0}}, 1'b0, 1'b0, 1'b1};
    end else begin
      push_entry = {alu_result, alu_zero, alu_overflow & op_has_ovf, 1'b0};
    end
    acc_d = (push && !illegal_q) ? alu_result : acc_q;
  end

  always_comb begin
    rsp_valid  = (count_q != '0);
    pop        = rsp_valid && rsp_ready;
    head_entry = rsp_valid ? mem_q[rd_ptr_q] : '0;
    wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d    = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_op_q  <= '0;
      illegal_q <= 1'b0;
      acc_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_op_q  <= alu_op_d;
      illegal_q <= illegal_d;
      acc_q     <= acc_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RSP_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
  end

  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_op       = alu_op_q;
  assign rsp_result   = head_entry[ENTRY_W-1:3];
  assign rsp_zero     = head_entry[2];
  assign rsp_overflow = head_entry[1];
  assign rsp_illegal  = head_entry[0];

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural 4-bit ALU on the pin side.
module tb_alu_cmd_sequencer;

   logic       clk;
   logic       rst;
   logic       cmdValid;
   logic       cmdReady;
   logic [2:0] cmdOp;
   logic       cmdAcc;
   logic [3:0] cmdA;
   logic [3:0] cmdB;
   logic [3:0] aluA;
   logic [3:0] aluB;
   logic [2:0] aluOp;
   logic [3:0] aluResult;
   logic       aluZero;
   logic       aluOvf;
   logic       rspValid;
   logic       rspReady;
   logic [3:0] rspResult;
   logic       rspZero;
   logic       rspOverflow;
   logic       rspIllegal;
   logic       busy;

   int totalChecks = 0;
   int badChecks   = 0;

   alu_cmd_sequencer #(.WIDTH(4), .RSP_DEPTH(2)) dut (
      .clk          (clk),
      .rst          (rst),
      .cmd_valid    (cmdValid),
      .cmd_ready    (cmdReady),
      .cmd_op       (cmdOp),
      .cmd_acc      (cmdAcc),
      .cmd_a        (cmdA),
      .cmd_b        (cmdB),
      .alu_a        (aluA),
      .alu_b        (aluB),
      .alu_op       (aluOp),
      .alu_result   (aluResult),
      .alu_zero     (aluZero),
      .alu_overflow (aluOvf),
      .rsp_valid    (rspValid),
      .rsp_ready    (rspReady),
      .rsp_result   (rspResult),
      .rsp_zero     (rspZero),
      .rsp_overflow (rspOverflow),
      .rsp_illegal  (rspIllegal),
      .busy         (busy)
   );

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural ALU; overflow is deliberately 1 for AND/OR/illegal so masking is visible.
   logic [3:0] sltDiff;
   always_comb begin
      aluResult = 4'b0000;
      aluOvf    = 1'b1;
      sltDiff   = 4'b0000;
      case (aluOp)
         3'b000: aluResult = aluA & aluB;
         3'b001: aluResult = aluA | aluB;
         3'b010: begin
            aluResult = aluA + aluB;
            aluOvf    = (aluA[3] == aluB[3]) && (aluResult[3] != aluA[3]);
         end
         3'b110: begin
            aluResult = aluA - aluB;
            aluOvf    = (aluA[3] != aluB[3]) && (aluResult[3] != aluA[3]);
         end
         3'b111: begin
            sltDiff   = aluA - aluB;
            aluOvf    = (aluA[3] != aluB[3]) && (sltDiff[3] != aluA[3]);
            aluResult = {3'b000, sltDiff[3] ^ aluOvf};
         end
         default: aluResult = aluA ^ aluB;
      endcase
      aluZero = (aluResult == 4'b0000);
   end

   // Global watchdog so a stuck handshake can never hang the run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      totalChecks++;
      if (obs !== exp) begin
         badChecks++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Presents one command and returns #1 after the accepting edge.
   task automatic applyStimulus(input logic [2:0] op, input logic acc,
                                input logic [3:0] a, input logic [3:0] b);
      int n = 0;
      cmdOp    = op;
      cmdAcc   = acc;
      cmdA     = a;
      cmdB     = b;
      cmdValid = 1'b1;
      while (!cmdReady && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!cmdReady) begin
         checkOutput("acceptTimeout", 8'(cmdReady), 8'd1);
         cmdValid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      cmdValid = 1'b0;
   endtask

   // Waits for the head entry, checks it, and pops it.
   task automatic popResponse(input string tag, input logic [3:0] res, input logic z,
                              input logic ovf, input logic ill);
      int n = 0;
      while (!rspValid && n < 10) begin
         @(posedge clk);
         #1;
         n++;
      end
      checkOutput({tag, "_valid"}, 8'(rspValid), 8'd1);
      checkOutput({tag, "_result"}, 8'(rspResult), 8'(res));
      checkOutput({tag, "_zero"}, 8'(rspZero), 8'(z));
      checkOutput({tag, "_ovf"}, 8'(rspOverflow), 8'(ovf));
      checkOutput({tag, "_illegal"}, 8'(rspIllegal), 8'(ill));
      rspReady = 1'b1;
      @(posedge clk);
      #1;
      rspReady = 1'b0;
   endtask

   // Main directed sequence.
   initial begin
      rst      = 1'b1;
      cmdValid = 1'b0;
      cmdOp    = 3'b000;
      cmdAcc   = 1'b0;
      cmdA     = 4'h0;
      cmdB     = 4'h0;
      rspReady = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      checkOutput("rstCmdReady", 8'(cmdReady), 8'd0);
      checkOutput("rstRspValid", 8'(rspValid), 8'd0);
      checkOutput("rstBusy", 8'(busy), 8'd0);
      checkOutput("rstAluOp", 8'(aluOp), 8'd0);
      checkOutput("rstRspResult", 8'(rspResult), 8'd0);
      rst = 1'b0;
      #1;
      checkOutput("relCmdReady", 8'(cmdReady), 8'd1);

      $display("[TB] latency: ADD 3+4");
      applyStimulus(3'b010, 1'b0, 4'd3, 4'd4);
      checkOutput("addBusy", 8'(busy), 8'd1);
      checkOutput("addEarlyValid", 8'(rspValid), 8'd0);
      checkOutput("addExecReady", 8'(cmdReady), 8'd0);
      checkOutput("addAluA", 8'(aluA), 8'd3);
      checkOutput("addAluB", 8'(aluB), 8'd4);
      checkOutput("addAluOp", 8'(aluOp), 8'd2);
      @(posedge clk);
      #1;
      checkOutput("addLatValid", 8'(rspValid), 8'd1);
      checkOutput("addIdleBusy", 8'(busy), 8'd0);
      popResponse("add34", 4'b0111, 1'b0, 1'b0, 1'b0);
      checkOutput("addEmpty", 8'(rspValid), 8'd0);

      $display("[TB] basic ops");
      applyStimulus(3'b110, 1'b0, 4'd5, 4'd5);
      popResponse("sub55", 4'b0000, 1'b1, 1'b0, 1'b0);
      applyStimulus(3'b010, 1'b0, 4'd7, 4'd1);
      popResponse("add71", 4'b1000, 1'b0, 1'b1, 1'b0);
      applyStimulus(3'b111, 1'b0, 4'b1101, 4'b0110);
      popResponse("slt", 4'b0001, 1'b0, 1'b1, 1'b0);
      applyStimulus(3'b000, 1'b0, 4'b1100, 4'b1010);
      popResponse("and", 4'b1000, 1'b0, 1'b0, 1'b0);
      applyStimulus(3'b001, 1'b0, 4'b0101, 4'b0010);
      popResponse("or", 4'b0111, 1'b0, 1'b0, 1'b0);

      $display("[TB] accumulator chain with illegal op");
      applyStimulus(3'b010, 1'b0, 4'd2, 4'd3);
      popResponse("chain1", 4'b0101, 1'b0, 1'b0, 1'b0);
      applyStimulus(3'b011, 1'b0, 4'd9, 4'd6);
      checkOutput("illAluOp", 8'(aluOp), 8'd3);
      popResponse("illegal", 4'b0000, 1'b0, 1'b0, 1'b1);
      applyStimulus(3'b010, 1'b1, 4'd15, 4'd1);
      checkOutput("accAluA", 8'(aluA), 8'd5);
      popResponse("chain2", 4'b0110, 1'b0, 1'b0, 1'b0);

      $display("[TB] backpressure");
      applyStimulus(3'b010, 1'b0, 4'd1, 4'd1);
      applyStimulus(3'b010, 1'b0, 4'd2, 4'd2);
      cmdOp    = 3'b010;
      cmdAcc   = 1'b0;
      cmdA     = 4'd3;
      cmdB     = 4'd3;
      cmdValid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         checkOutput("fullReady", 8'(cmdReady), 8'd0);
      end
      popResponse("bp1", 4'd2, 1'b0, 1'b0, 1'b0);
      checkOutput("afterPopReady", 8'(cmdReady), 8'd1);
      @(posedge clk);
      #1;
      cmdValid = 1'b0;
      checkOutput("thirdBusy", 8'(busy), 8'd1);
      popResponse("bp2", 4'd4, 1'b0, 1'b0, 1'b0);
      popResponse("bp3", 4'd6, 1'b0, 1'b0, 1'b0);
      checkOutput("bpEmpty", 8'(rspValid), 8'd0);

      $display("[TB] same-cycle push and pop");
      applyStimulus(3'b010, 1'b0, 4'd1, 4'd2);
      applyStimulus(3'b010, 1'b0, 4'd4, 4'd4);
      checkOutput("ppHead", 8'(rspResult), 8'd3);
      rspReady = 1'b1;
      @(posedge clk);
      #1;
      rspReady = 1'b0;
      checkOutput("ppValid", 8'(rspValid), 8'd1);
      popResponse("pp2", 4'b1000, 1'b0, 1'b1, 1'b0);
      checkOutput("ppEmpty", 8'(rspValid), 8'd0);

      $display("[TB] reset during EXEC");
      applyStimulus(3'b010, 1'b0, 4'd1, 4'd1);
      applyStimulus(3'b010, 1'b0, 4'd5, 4'd1);
      checkOutput("preRstBusy", 8'(busy), 8'd1);
      rst = 1'b1;
      #2;
      checkOutput("midRstValid", 8'(rspValid), 8'd0);
      checkOutput("midRstBusy", 8'(busy), 8'd0);
      checkOutput("midRstReady", 8'(cmdReady), 8'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      checkOutput("postRstReady", 8'(cmdReady), 8'd1);
      checkOutput("postRstValid", 8'(rspValid), 8'd0);
      applyStimulus(3'b010, 1'b1, 4'd9, 4'd3);
      checkOutput("postRstAcc", 8'(aluA), 8'd0);
      popResponse("postRst", 4'd3, 1'b0, 1'b0, 1'b0);
      checkOutput("finalEmpty", 8'(rspValid), 8'd0);

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule
